// File: rtl/writeback_pkg.sv
// Shared register-file types for the writeback slice: register address, data word,
// and the address/data pair carried through the load-result FIFO.
package writeback_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef struct packed {
        addr_t addr;
        word_t data;
    } wb_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; head is visible combinationally while non-empty.
module wb_fifo
    import writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  wb_t  push_data,
    input  logic pop,
    output wb_t  head,
    output logic full,
    output logic empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    wb_t              mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/writeback.sv
// Register-file write port: arbitrates ALU results against buffered loads, tracks
// pending loads for issue interlock, and bypasses the in-flight write to rs1/rs2.
module writeback
    import writeback_pkg::*;
#(
    parameter int LSU_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_addr,
    input  logic [31:0] lsu_data,
    input  logic        pend_en,
    input  logic [4:0]  pend_addr,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rd_en,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data
);
    wb_t         lsu_wb;
    wb_t         lsu_head;
    wb_t         sel_wb;
    logic        fifo_full;
    logic        fifo_empty;
    logic        alu_acc;
    logic        fifo_pop;
    logic        wr_vld;
    logic        wr_load;
    logic        vld_p1;
    logic        load_p1;
    wb_t         wb_p1;
    logic [31:0] busy;

    assign lsu_wb.addr = lsu_addr;
    assign lsu_wb.data = lsu_data;

    wb_fifo #(.DEPTH(LSU_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (lsu_valid && lsu_ready),
        .push_data (lsu_wb),
        .pop       (fifo_pop),
        .head      (lsu_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign alu_ready = !fifo_full;
    assign lsu_ready = !fifo_full;

    // A full FIFO always drains so loads can never be starved by a busy ALU.
    always_comb begin
        alu_acc     = alu_valid && !fifo_full;
        fifo_pop    = fifo_full || (!alu_acc && !fifo_empty);
        wr_vld      = alu_acc || fifo_pop;
        wr_load     = !alu_acc;
        sel_wb      = lsu_head;
        if (alu_acc) begin
            sel_wb.addr = alu_addr;
            sel_wb.data = alu_data;
        end
    end

    // ---- stage p1: registered write port ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            load_p1 <= 1'b0;
            wb_p1   <= '0;
        end else begin
            vld_p1  <= wr_vld && (sel_wb.addr != '0);
            load_p1 <= wr_load;
            if (wr_vld) wb_p1 <= sel_wb;
        end
    end

    assign rd_en   = vld_p1;
    assign rd_addr = wb_p1.addr;
    assign rd_data = wb_p1.data;

    // Set is written after clear so a same-cycle set of the same register wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            if (vld_p1 && load_p1) busy[wb_p1.addr] <= 1'b0;
            if (pend_en && (pend_addr != '0)) busy[pend_addr] <= 1'b1;
        end
    end

    assign rs1_busy = (rs1_addr != '0) && busy[rs1_addr];
    assign rs2_busy = (rs2_addr != '0) && busy[rs2_addr];

    assign rs1_data = (vld_p1 && (wb_p1.addr == rs1_addr) && (rs1_addr != '0)) ? wb_p1.data : rf_rs1_data;
    assign rs2_data = (vld_p1 && (wb_p1.addr == rs2_addr) && (rs2_addr != '0)) ? wb_p1.data : rf_rs2_data;
endmodule

// File: tb/tb_writeback.sv
// Bench for writeback: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_writeback;
    localparam int D = 4;

    logic        clk;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_addr;
    logic [31:0] lsu_data;
    logic        pend_en;
    logic [4:0]  pend_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rf_rs1_data;
    logic [31:0] rf_rs2_data;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    writeback #(.LSU_DEPTH(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_addr    (lsu_addr),
        .lsu_data    (lsu_data),
        .pend_en     (pend_en),
        .pend_addr   (pend_addr),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rf_rs1_data (rf_rs1_data),
        .rf_rs2_data (rf_rs2_data),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: pending loads in arrival order, busy set, expected write port.
    logic [4:0]  mq_addr [$];
    logic [31:0] mq_data [$];
    bit          mbusy [32];
    bit          model_on = 0;
    bit          exp_en = 0;
    bit          exp_load = 0;
    logic [4:0]  exp_addr = '0;
    logic [31:0] exp_data = '0;

    always @(posedge clk) begin
        bit          is_full, take_alu, take_load, have;
        logic [4:0]  w_addr;
        logic [31:0] w_data;
        if (reset) begin
            mq_addr.delete();
            mq_data.delete();
            foreach (mbusy[i]) mbusy[i] = 0;
            exp_en   = 0;
            exp_load = 0;
            exp_addr = '0;
            exp_data = '0;
            model_on = 1;
        end else if (model_on) begin
            is_full   = (mq_addr.size() == D);
            take_alu  = alu_valid && !is_full;
            take_load = !take_alu && (mq_addr.size() > 0);
            have      = take_alu || take_load;
            w_addr    = take_alu ? alu_addr : (take_load ? mq_addr[0] : 5'd0);
            w_data    = take_alu ? alu_data : (take_load ? mq_data[0] : 32'd0);
            if (exp_en && exp_load) mbusy[exp_addr] = 0;
            if (pend_en && pend_addr != 0) mbusy[pend_addr] = 1;
            if (take_load) begin
                void'(mq_addr.pop_front());
                void'(mq_data.pop_front());
            end
            if (lsu_valid && !is_full) begin
                mq_addr.push_back(lsu_addr);
                mq_data.push_back(lsu_data);
            end
            exp_en   = have && (w_addr != 0);
            exp_load = take_load;
            if (have) begin
                exp_addr = w_addr;
                exp_data = w_data;
            end
        end
    end

    logic [4:0]  obs_addr [$];
    logic [31:0] obs_data [$];
    int          rd_cnt = 0;
    bit          saw_blocked = 0;

    always @(negedge clk) begin
        if (model_on) begin
            chk("rd_en", {31'd0, rd_en}, {31'd0, exp_en});
            if (exp_en) begin
                chk("rd_addr", {27'd0, rd_addr}, {27'd0, exp_addr});
                chk("rd_data", rd_data, exp_data);
            end
            chk("alu_ready", {31'd0, alu_ready}, {31'd0, mq_addr.size() != D});
            chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, mq_addr.size() != D});
            chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, (rs1_addr != 0) && mbusy[rs1_addr]});
            chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, (rs2_addr != 0) && mbusy[rs2_addr]});
            chk("rs1_data", rs1_data,
                (exp_en && exp_addr == rs1_addr && rs1_addr != 0) ? exp_data : rf_rs1_data);
            chk("rs2_data", rs2_data,
                (exp_en && exp_addr == rs2_addr && rs2_addr != 0) ? exp_data : rf_rs2_data);
            if (rd_en) rd_cnt++;
            if (!alu_ready) saw_blocked = 1;
            if (rd_en && rd_addr >= 5'd20 && rd_addr <= 5'd23) begin
                obs_addr.push_back(rd_addr);
                obs_data.push_back(rd_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt0;
        reset = 1; alu_valid = 0; alu_addr = 0; alu_data = 0;
        lsu_valid = 0; lsu_addr = 0; lsu_data = 0; pend_en = 0; pend_addr = 0;
        rs1_addr = 0; rs2_addr = 0; rf_rs1_data = 32'h1111_1111; rf_rs2_data = 32'h2222_2222;
        tick(); tick();
        reset = 0;
        #1;
        chk("reset_rd_en", {31'd0, rd_en}, 32'd0);
        chk("reset_rd_addr", {27'd0, rd_addr}, 32'd0);
        chk("reset_rd_data", rd_data, 32'd0);
        chk("reset_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("reset_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        tick();

        // Scenario 1: single ALU write
        alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF;
        tick();
        alu_valid = 0;
        #1;
        chk("s1_rd_en", {31'd0, rd_en}, 32'd1);
        chk("s1_rd_addr", {27'd0, rd_addr}, 32'd5);
        chk("s1_rd_data", rd_data, 32'hDEADBEEF);
        tick();

        // Scenario 2: pending load interlock on x7
        pend_en = 1; pend_addr = 7;
        tick();
        pend_en = 0; rs1_addr = 7; rf_rs1_data = 0;
        #1;
        chk("s2_busy_set", {31'd0, rs1_busy}, 32'd1);
        lsu_valid = 1; lsu_addr = 7; lsu_data = 32'h1234;
        tick();
        lsu_valid = 0;
        #1;
        chk("s2_no_early_write", {31'd0, rd_en}, 32'd0);
        chk("s2_busy_hold", {31'd0, rs1_busy}, 32'd1);
        tick();
        chk("s2_load_en", {31'd0, rd_en}, 32'd1);
        chk("s2_load_addr", {27'd0, rd_addr}, 32'd7);
        chk("s2_load_data", rd_data, 32'h1234);
        chk("s2_busy_during", {31'd0, rs1_busy}, 32'd1);
        chk("s2_bypass", rs1_data, 32'h1234);
        tick();
        chk("s2_busy_clear", {31'd0, rs1_busy}, 32'd0);
        chk("s2_rd_idle", {31'd0, rd_en}, 32'd0);

        // Scenario 3: ALU streaming while 4 loads fill the FIFO
        for (int i = 0; i < 12; i++) begin
            alu_valid = 1; alu_addr = 5'(1 + i % 6); alu_data = 32'hA000 + i;
            lsu_valid = (i < 4); lsu_addr = 5'(20 + i); lsu_data = 32'h1000 + i;
            pend_en = (i < 4); pend_addr = 5'(20 + i);
            tick();
        end
        alu_valid = 0; lsu_valid = 0; pend_en = 0;
        repeat (6) tick();
        chk("s3_alu_blocked", {31'd0, saw_blocked}, 32'd1);
        chk("s3_load_count", obs_addr.size(), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < obs_addr.size()) begin
                chk("s3_load_addr", {27'd0, obs_addr[k]}, 32'(20 + k));
                chk("s3_load_data", obs_data[k], 32'h1000 + k);
            end
        end
        rs1_addr = 20; rs2_addr = 23;
        #1;
        chk("s3_busy20_clear", {31'd0, rs1_busy}, 32'd0);
        chk("s3_busy23_clear", {31'd0, rs2_busy}, 32'd0);
        tick();

        // Scenario 4: write to x0 is swallowed
        alu_valid = 1; alu_addr = 0; alu_data = 32'hFFFFFFFF;
        #1;
        chk("s4_accepted", {31'd0, alu_ready}, 32'd1);
        tick();
        alu_valid = 0; rs1_addr = 0; rf_rs1_data = 0;
        #1;
        chk("s4_rd_en", {31'd0, rd_en}, 32'd0);
        chk("s4_rs1_data", rs1_data, 32'd0);
        chk("s4_rs1_busy", {31'd0, rs1_busy}, 32'd0);
        tick();

        // Scenario 5: bypass onto rs2
        alu_valid = 1; alu_addr = 3; alu_data = 32'hA5A5A5A5;
        tick();
        alu_valid = 0; rs2_addr = 3; rf_rs2_data = 0;
        #1;
        chk("s5_rs2_bypass", rs2_data, 32'hA5A5A5A5);
        tick();
        chk("s5_rs2_raw", rs2_data, 32'd0);

        // Scenario 6: reset with three loads queued and two busy bits
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_addr = 1; alu_data = 32'hB000 + i;
            lsu_valid = 1; lsu_addr = (i == 2) ? 5'd11 : 5'(8 + i); lsu_data = 32'hC000 + i;
            pend_en = (i < 2); pend_addr = 5'(8 + i);
            tick();
        end
        lsu_valid = 0; pend_en = 0; rs1_addr = 8; rs2_addr = 9;
        #1;
        chk("s6_busy8_pre", {31'd0, rs1_busy}, 32'd1);
        chk("s6_busy9_pre", {31'd0, rs2_busy}, 32'd1);
        reset = 1; alu_valid = 0;
        tick();
        reset = 0;
        #1;
        chk("s6_rd_en", {31'd0, rd_en}, 32'd0);
        chk("s6_rd_addr", {27'd0, rd_addr}, 32'd0);
        chk("s6_rd_data", rd_data, 32'd0);
        chk("s6_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        chk("s6_busy8", {31'd0, rs1_busy}, 32'd0);
        chk("s6_busy9", {31'd0, rs2_busy}, 32'd0);
        cnt0 = rd_cnt;
        repeat (6) tick();
        chk("s6_no_stale", rd_cnt, cnt0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
